// File: rtl/midi_rx.sv
// MIDI input receiver: 2-flop synchronizer, 8N1 UART front end and a
// channel-voice parser with running status that emits Note On/Off events.
module midi_rx #(
   parameter int CLK_RATE = 50000000,
   parameter int BAUD     = 31250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       midi_in,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       frame_err,
   output logic       evt_valid,
   output logic       evt_note_on,
   output logic [3:0] evt_channel,
   output logic [6:0] evt_note,
   output logic [6:0] evt_velocity
);

   localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } uart_state_t;

   logic             sync1_q, sync2_q;
   uart_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic [7:0]       rx_byte_q;
   logic             rx_valid_q;
   logic             frame_err_q;

   logic [7:0]       rs_q, rs_d;
   logic             cnt1_q, cnt1_d;
   logic [6:0]       d1_q, d1_d;
   logic             evt_valid_q, evt_valid_d;
   logic             evt_on_q, evt_on_d;
   logic [3:0]       evt_ch_q, evt_ch_d;
   logic [6:0]       evt_note_q, evt_note_d;
   logic [6:0]       evt_vel_q, evt_vel_d;
   logic             short_msg;
   logic             is_realtime;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= midi_in;
         sync2_q <= sync1_q;
      end
   end

   // UART: sample mid-bit, counting from the centre of the start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!sync2_q) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  state_q <= sync2_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt_q   <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     rx_byte_q  <= shift_q;
                     rx_valid_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (sync2_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Parser: rs_q[7] doubles as the "running status valid" flag
   assign short_msg   = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
   assign is_realtime = (rx_byte_q[7:3] == 5'b11111);

   always_comb begin
      rs_d        = rs_q;
      cnt1_d      = cnt1_q;
      d1_d        = d1_q;
      evt_valid_d = 1'b0;
      evt_on_d    = evt_on_q;
      evt_ch_d    = evt_ch_q;
      evt_note_d  = evt_note_q;
      evt_vel_d   = evt_vel_q;
      if (rx_valid_q && !is_realtime) begin
         if (rx_byte_q[7:4] == 4'hF) begin
            rs_d   = '0;
            cnt1_d = 1'b0;
         end else if (rx_byte_q[7]) begin
            rs_d   = rx_byte_q;
            cnt1_d = 1'b0;
         end else if (rs_q[7]) begin
            if (!cnt1_q && !short_msg) begin
               d1_d   = rx_byte_q[6:0];
               cnt1_d = 1'b1;
            end else begin
               cnt1_d = 1'b0;
               if ((rs_q[7:4] == 4'h9) || (rs_q[7:4] == 4'h8)) begin
                  evt_valid_d = 1'b1;
                  evt_on_d    = (rs_q[7:4] == 4'h9) && (rx_byte_q[6:0] != 7'd0);
                  evt_ch_d    = rs_q[3:0];
                  evt_note_d  = d1_q;
                  evt_vel_d   = rx_byte_q[6:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_q        <= '0;
         cnt1_q      <= 1'b0;
         d1_q        <= '0;
         evt_valid_q <= 1'b0;
         evt_on_q    <= 1'b0;
         evt_ch_q    <= '0;
         evt_note_q  <= '0;
         evt_vel_q   <= '0;
      end else begin
         rs_q        <= rs_d;
         cnt1_q      <= cnt1_d;
         d1_q        <= d1_d;
         evt_valid_q <= evt_valid_d;
         evt_on_q    <= evt_on_d;
         evt_ch_q    <= evt_ch_d;
         evt_note_q  <= evt_note_d;
         evt_vel_q   <= evt_vel_d;
      end
   end

   assign rx_byte       = rx_byte_q;
   assign rx_byte_valid = rx_valid_q;
   assign frame_err     = frame_err_q;
   assign evt_valid     = evt_valid_q;
   assign evt_note_on   = evt_on_q;
   assign evt_channel   = evt_ch_q;
   assign evt_note      = evt_note_q;
   assign evt_velocity  = evt_vel_q;

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx at 16 clocks per bit: byte/event
// expectations are queued as stimulus is sent and popped as the DUT emits.
module tb_midi_rx;

   localparam int BAUD = 31250;
   localparam int CPB  = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       midi_in;
   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic       frame_err;
   logic       evt_valid;
   logic       evt_note_on;
   logic [3:0] evt_channel;
   logic [6:0] evt_note;
   logic [6:0] evt_velocity;

   midi_rx #(.CLK_RATE(BAUD * CPB), .BAUD(BAUD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .midi_in      (midi_in),
      .rx_byte      (rx_byte),
      .rx_byte_valid(rx_byte_valid),
      .frame_err    (frame_err),
      .evt_valid    (evt_valid),
      .evt_note_on  (evt_note_on),
      .evt_channel  (evt_channel),
      .evt_note     (evt_note),
      .evt_velocity (evt_velocity)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic       evt;
      logic       on;
      logic [3:0] ch;
      logic [6:0] note;
      logic [6:0] vel;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  exp_rx_q[$];
   logic [18:0] exp_evt_q[$];

   int total = 0;
   int passed = 0;
   int rbv_cnt = 0;
   int evt_cnt = 0;
   int fe_cnt = 0;
   logic prev_rbv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_byte_valid) begin
            rbv_cnt++;
            if (exp_rx_q.size() == 0) begin
               total++;
               $display("FAIL rx_unexpected: got 0x%0h, want no byte", rx_byte);
            end else begin
               chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx_q.pop_front()});
            end
         end
         if (evt_valid) begin
            evt_cnt++;
            chk("evt_latency", {31'd0, prev_rbv}, 32'd1);
            if (exp_evt_q.size() == 0) begin
               total++;
               $display("FAIL evt_unexpected: got %0b/%0d/%0d/%0d, want no event",
                        evt_note_on, evt_channel, evt_note, evt_velocity);
            end else begin
               chk("evt_fields", {13'd0, evt_note_on, evt_channel, evt_note, evt_velocity},
                   {13'd0, exp_evt_q.pop_front()});
            end
         end
         if (frame_err) fe_cnt++;
         prev_rbv = rx_byte_valid;
      end else begin
         prev_rbv = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      midi_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         midi_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      midi_in = stop;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_rx_q.push_back(b);
      send_byte(b, 1'b1);
   endtask

   task automatic settle_and_drain(input string tag);
      midi_in = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk({tag, "_rx_drained"}, exp_rx_q.size(), 0);
      chk({tag, "_evt_drained"}, exp_evt_q.size(), 0);
   endtask

   function automatic logic [29:0] all_outs();
      return {rx_byte, rx_byte_valid, frame_err, evt_valid, evt_note_on,
              evt_channel, evt_note, evt_velocity};
   endfunction

   initial begin
      int rb0, fe0, ev0;
      // {byte, event?, on, channel, note, velocity}
      vecs.push_back('{8'h90, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h64, 1'b1, 1'b1, 4'd0, 7'd60, 7'd100});
      vecs.push_back('{8'h95, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h40, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h7F, 1'b1, 1'b1, 4'd5, 7'd64, 7'd127});
      vecs.push_back('{8'h40, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h00, 1'b1, 1'b0, 4'd5, 7'd64, 7'd0});
      vecs.push_back('{8'h83, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h30, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h10, 1'b1, 1'b0, 4'd3, 7'd48, 7'd16});
      vecs.push_back('{8'h90, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'hF8, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h64, 1'b1, 1'b1, 4'd0, 7'd60, 7'd100});
      vecs.push_back('{8'hC2, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h05, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h64, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h64, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'hF7, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});
      vecs.push_back('{8'h64, 1'b0, 1'b0, 4'd0, 7'd0,  7'd0});

      rst_n   = 1'b0;
      midi_in = 1'b1;
      #1;
      chk("reset_outputs", {2'd0, all_outs()}, 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);

      // Table: bytes sent back to back
      ev0 = evt_cnt;
      foreach (vecs[i]) begin
         if (vecs[i].evt)
            exp_evt_q.push_back({vecs[i].on, vecs[i].ch, vecs[i].note, vecs[i].vel});
         expect_byte(vecs[i].b);
      end
      settle_and_drain("table");
      chk("table_evt_count", evt_cnt - ev0, 5);

      // Bad stop bit followed by a 40-bit break
      rb0 = rbv_cnt;
      fe0 = fe_cnt;
      send_byte(8'h55, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      chk("break_frame_err", fe_cnt - fe0, 1);
      chk("break_no_rx", rbv_cnt - rb0, 0);
      midi_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      exp_evt_q.push_back({1'b0, 4'd0, 7'd60, 7'd0});
      expect_byte(8'h80);
      expect_byte(8'h3C);
      expect_byte(8'h00);
      settle_and_drain("after_break");

      // Short glitch must not start a byte
      rb0 = rbv_cnt;
      fe0 = fe_cnt;
      @(negedge clk);
      midi_in = 1'b0;
      repeat (3) @(negedge clk);
      midi_in = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      chk("glitch_no_rx", rbv_cnt - rb0, 0);
      chk("glitch_no_fe", fe_cnt - fe0, 0);

      // Reset in the middle of a data bit, with running status 0x90 live
      expect_byte(8'h90);
      settle_and_drain("pre_reset");
      @(negedge clk);
      midi_in = 1'b0;
      repeat (CPB) @(negedge clk);
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midbyte_reset_outputs", {2'd0, all_outs()}, 32'd0);
      midi_in = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("post_reset_no_rx", rbv_cnt, rb0 + 1);
      ev0 = evt_cnt;
      expect_byte(8'h3C);
      expect_byte(8'h64);
      exp_evt_q.push_back({1'b1, 4'd0, 7'd60, 7'd100});
      expect_byte(8'h90);
      expect_byte(8'h3C);
      expect_byte(8'h64);
      settle_and_drain("post_reset");
      chk("post_reset_evt_count", evt_cnt - ev0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
